word_serializer: RTL and testbench

//   Parallel-to-serial front end for the serial two's-complement stage.
//   - Accepts a WIDTH-bit word over a valid/ready handshake.
//   - Emits the word one bit per t_clk, LSB first.
//   - Marks the first bit of each word with ser_start (clears the downstream bit-serial state).
//   - Sits directly upstream: ser_bit drives the complementer's data input, ser_start drives its clear input.

---
 rtl/serial_pkg.sv | 22 ++
 rtl/ser_bit_counter.sv | 53 +++++
 rtl/word_serializer.sv | 120 ++++++++++++
 tb/tb_word_serializer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
//   Shared types and helpers for the word serializer front end.
//   - ser_state_t : serializer FSM states
//   - DEFAULT_WIDTH : default word length
//   - cnt_width() : bit-counter width for a given word length
// ---------------------------------------------------------------------------
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int DEFAULT_WIDTH = 8;

    // $clog2(width), floored at 1 so the counter never collapses to zero bits.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// ---------------------------------------------------------------------------
// ser_bit_counter
//   Mod-WIDTH bit position counter for the serializer.
//   Ports:
//     t_clk, rst_n : clock, async active-low reset
//     clear        : next count is 0 (takes priority over inc)
//     inc          : advance by one, wrapping after WIDTH-1
//     cnt          : current bit position
//     is_first     : the count taking effect at the next edge is 0
//     is_last      : the count taking effect at the next edge is WIDTH-1
// ---------------------------------------------------------------------------
module ser_bit_counter
    import serial_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             t_clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             is_first,
    output logic             is_last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (clear) begin
            cnt_nxt = '0;
        end else if (inc) begin
            cnt_nxt = (cnt == LAST_CNT) ? '0 : cnt + CNT_W'(1);
        end
    end

    // Flags look one step ahead so the top can register its outputs
    // against the bit that will be on the wire after the next edge.
    assign is_first = (cnt_nxt == '0);
    assign is_last  = (cnt_nxt == LAST_CNT);

    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/word_serializer.sv
// ---------------------------------------------------------------------------
// word_serializer
//   Parallel-to-serial front end: takes a WIDTH-bit word over valid/ready
//   and emits it LSB first, one bit per clock, marking first/last bits.
//   Ports:
//     t_clk, rst_n : clock, async active-low reset
//     in_data      : parallel word, sampled only on the accepting edge
//     in_valid     : in_data is valid
//     in_ready     : word can be taken this cycle (from state/counter only)
//     ser_bit      : serial data, LSB first (registered)
//     ser_start    : high with bit 0 of each word (registered)
//     ser_last     : high with bit WIDTH-1 of each word (registered)
//     ser_valid    : ser_bit carries a word bit (registered)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no word in flight, outputs 0, ready for a word
//   SHIFT | word on the wire; ready only while its last bit is out
// ---------------------------------------------------------------------------
module word_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             t_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_start,
    output logic             ser_last,
    output logic             ser_valid
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    ser_state_t       state;
    ser_state_t       state_d;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_d;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clear;
    logic             cnt_inc;
    logic             nxt_first;
    logic             nxt_last;
    logic             at_last;
    logic             accept;
    logic             valid_d;

    ser_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .t_clk    (t_clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .inc      (cnt_inc),
        .cnt      (cnt),
        .is_first (nxt_first),
        .is_last  (nxt_last)
    );

    assign at_last  = (state == SHIFT) && (cnt == LAST_CNT);
    assign in_ready = (state == IDLE) || at_last;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state;
        sreg_d    = sreg;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                cnt_clear = 1'b1;
                if (accept) begin
                    state_d = SHIFT;
                    sreg_d  = in_data;
                end
            end
            SHIFT: begin
                if (accept) begin
                    // Reload on the last bit: next word follows with no bubble.
                    sreg_d    = in_data;
                    cnt_clear = 1'b1;
                end else if (at_last) begin
                    state_d   = IDLE;
                    sreg_d    = '0;
                    cnt_clear = 1'b1;
                end else begin
                    sreg_d  = {1'b0, sreg[WIDTH-1:1]};
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_clear = 1'b1;
            end
        endcase
    end

    assign valid_d = (state_d == SHIFT);

    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sreg      <= '0;
            ser_bit   <= 1'b0;
            ser_start <= 1'b0;
            ser_last  <= 1'b0;
            ser_valid <= 1'b0;
        end else begin
            state     <= state_d;
            sreg      <= sreg_d;
            ser_bit   <= valid_d && sreg_d[0];
            ser_start <= valid_d && nxt_first;
            ser_last  <= valid_d && nxt_last;
            ser_valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// ---------------------------------------------------------------------------
// tb_word_serializer
//   Self-checking bench for word_serializer (WIDTH=8). A queue of expected
//   output beats is filled whenever the model accepts a word and drained one
//   beat per clock; directed cases also compare reassembled words.
// ---------------------------------------------------------------------------
module tb_word_serializer;

    localparam int WIDTH = 8;

    logic             t_clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_bit;
    logic             ser_start;
    logic             ser_last;
    logic             ser_valid;

    word_serializer #(.WIDTH(WIDTH)) dut (
        .t_clk     (t_clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_bit   (ser_bit),
        .ser_start (ser_start),
        .ser_last  (ser_last),
        .ser_valid (ser_valid)
    );

    always #5 t_clk = ~t_clk;

    typedef struct {
        logic b;
        logic s;
        logic l;
    } beat_t;

    beat_t expq[$];
    logic  seen_bits[$];
    logic  seen_start[$];
    int    ready_hi;
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, ser_valid, 1'b0);
        chk({tag, "_bit"},   ser_bit,   1'b0);
        chk({tag, "_start"}, ser_start, 1'b0);
        chk({tag, "_last"},  ser_last,  1'b0);
        chk({tag, "_ready"}, in_ready,  1'b1);
    endtask

    // One clock: drive inputs, let the model decide acceptance (it is ready
    // exactly when nothing remains queued beyond the beat now on the wire),
    // then check the beat shown after the edge.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d);
        beat_t e;
        in_valid = v;
        in_data  = d;
        if (v && expq.size() == 0) begin
            for (int i = 0; i < WIDTH; i++) begin
                e.b = d[i];
                e.s = (i == 0);
                e.l = (i == WIDTH - 1);
                expq.push_back(e);
            end
        end
        @(posedge t_clk);
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("ser_valid", ser_valid, 1'b1);
            chk("ser_bit",   ser_bit,   e.b);
            chk("ser_start", ser_start, e.s);
            chk("ser_last",  ser_last,  e.l);
        end else begin
            chk("idle_valid", ser_valid, 1'b0);
            chk("idle_bit",   ser_bit,   1'b0);
            chk("idle_start", ser_start, 1'b0);
            chk("idle_last",  ser_last,  1'b0);
        end
        chk("in_ready", in_ready, expq.size() == 0);
        if (ser_valid) begin
            seen_bits.push_back(ser_bit);
            seen_start.push_back(ser_start);
        end
        if (in_ready) ready_hi++;
    endtask

    task automatic clear_seen();
        seen_bits.delete();
        seen_start.delete();
        ready_hi = 0;
    endtask

    task automatic get_word(output logic [WIDTH-1:0] w);
        w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (seen_bits.size() > 0) begin
                w[i] = seen_bits.pop_front();
                void'(seen_start.pop_front());
            end
        end
    endtask

    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] tc;
    logic             seen_one;
    int               n_starts;

    initial begin
        in_valid = 1'b0;
        in_data  = '0;
        clear_seen();

        // Reset state.
        #2;
        chk_idle("rst");
        @(negedge t_clk);
        rst_n = 1'b1;

        // 1: idle for 20 cycles.
        clear_seen();
        repeat (20) cycle(1'b0, WIDTH'($urandom));
        chk("t1_ready_cycles", ready_hi, 20);
        chk("t1_valid_beats", seen_bits.size(), 0);

        // 2: single word.
        clear_seen();
        cycle(1'b1, 8'hB4);
        repeat (8) cycle(1'b0, WIDTH'($urandom));
        chk("t2_beats", seen_bits.size(), 8);
        n_starts = 0;
        foreach (seen_start[i]) if (seen_start[i]) n_starts++;
        chk("t2_starts", n_starts, 1);
        get_word(w);
        chk("t2_word", w, 8'hB4);

        // 3: back-to-back with in_valid held high.
        clear_seen();
        cycle(1'b1, 8'h01);
        repeat (7) cycle(1'b1, 8'h80);
        chk("t3_ready_first_word", ready_hi, 1);
        cycle(1'b1, 8'h80);
        repeat (7) cycle(1'b0, WIDTH'($urandom));
        chk("t3_contig_beats", seen_bits.size(), 16);
        n_starts = 0;
        foreach (seen_start[i]) if (seen_start[i]) n_starts++;
        chk("t3_starts", n_starts, 2);
        if (seen_start.size() > 8) chk("t3_start_at_9", seen_start[8], 1'b1);
        get_word(w);
        chk("t3_word0", w, 8'h01);
        get_word(w);
        chk("t3_word1", w, 8'h80);
        cycle(1'b0, 8'h00);

        // 4: in_data churns while the word is in flight.
        clear_seen();
        cycle(1'b1, 8'h5A);
        repeat (8) cycle(1'b0, WIDTH'($urandom));
        get_word(w);
        chk("t4_word", w, 8'h5A);

        // 5: asynchronous reset during bit 3.
        cycle(1'b1, 8'hFF);
        repeat (3) cycle(1'b0, WIDTH'($urandom));
        chk("t5_pre_valid", ser_valid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_idle("t5_async");
        expq.delete();
        clear_seen();
        @(posedge t_clk);
        #1;
        chk_idle("t5_held");
        @(negedge t_clk);
        rst_n = 1'b1;
        cycle(1'b1, 8'h03);
        repeat (8) cycle(1'b0, WIDTH'($urandom));
        chk("t5_beats", seen_bits.size(), 8);
        get_word(w);
        chk("t5_word", w, 8'h03);

        // 6: downstream serial two's complementer fed by the stream.
        clear_seen();
        cycle(1'b1, 8'h06);
        repeat (8) cycle(1'b0, WIDTH'($urandom));
        tc       = '0;
        seen_one = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < seen_bits.size()) begin
                if (seen_start[i]) seen_one = 1'b0;
                tc[i] = seen_one ? ~seen_bits[i] : seen_bits[i];
                if (seen_bits[i]) seen_one = 1'b1;
            end
        end
        chk("t6_twos_comp", tc, 8'hFA);

        // Randomized traffic against the beat queue.
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 3) != 0, WIDTH'($urandom));
        end
        repeat (10) cycle(1'b0, WIDTH'($urandom));
        chk("drain", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
